proc_test_harness: RTL

- Synthesizable run controller that replaces fixed-delay testbench sequencing around `rv32_processor`.
- Sequences the core's active-low reset, then counts cycles and retired instructions.
- Watches the data-memory store bus for a tohost-style completion write and ends the run with PASS, FAIL(code) or TIMEOUT.
- Sits between the bench and the core; the same block serves every program image.

---
 rtl/harness_pkg.sv | 30 +++
 rtl/pc_trace_buf.sv | 51 +++++
 rtl/proc_test_harness.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/harness_pkg.sv
`default_nettype none
// ============================================================================
// Module   : harness_pkg
// Purpose  : Shared types and constants for the proc_test_harness run
//            controller: the controller state encoding and the tohost value
//            that signals a passing program.
// Revision : 1.0 - initial release
// ============================================================================
package harness_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RST_HOLD = 3'd1,
    ST_RUN      = 3'd2,
    ST_PASS     = 3'd3,
    ST_FAIL     = 3'd4,
    ST_TIMEOUT  = 3'd5
  } harness_state_t;

  // Value a program writes to tohost to report success.
  localparam int unsigned PASS_CODE = 1;

  // Hold-counter preload: the counter runs down to zero, so a hold of N
  // cycles starts from N-1.
  function automatic logic [7:0] hold_preload(input int unsigned cycles);
    return 8'(cycles - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : pc_trace_buf
// Purpose  : Circular history of retired-instruction PCs. Index 0 on the
//            read port returns the most recently written PC.
// Ports    : clk, reset   - clock, synchronous active-high reset
//            clear        - empties the history (new run)
//            wr_en        - append wr_data as the newest entry
//            wr_data      - PC to record
//            rd_idx       - age of entry to read (0 = newest)
//            rd_data      - selected PC (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module pc_trace_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [XLEN-1:0]          wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [XLEN-1:0]          rd_data
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [XLEN-1:0]  entries [DEPTH];
  logic [IDX_W-1:0] wptr;
  logic [IDX_W-1:0] rd_slot;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (wr_en) begin
      entries[wptr] <= wr_data;
      wptr          <= wptr + IDX_W'(1);
    end
  end

  // wptr points at the next free slot; the newest entry sits one behind it.
  // DEPTH is a power of two, so the subtraction wraps naturally.
  assign rd_slot = wptr - IDX_W'(1) - rd_idx;
  assign rd_data = entries[rd_slot];

endmodule
`default_nettype wire

// File: rtl/proc_test_harness.sv
`default_nettype none
// ============================================================================
// Module   : proc_test_harness
// Purpose  : Run controller for a processor core under test. Sequences the
//            core's active-low reset, counts run cycles and retired
//            instructions, and ends the run on a tohost completion store
//            (PASS / FAIL with code) or on a cycle limit (TIMEOUT).
// Config   : HARNESS_TRACE_EN - when defined, keeps a TRACE_DEPTH-entry
//            history of retired PCs readable through trace_idx/trace_pc.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            start               - one-cycle pulse, begins a run
//            core_resetn         - drives the core's resetn
//            retire, pc          - core retirement strobe and PC
//            st_en/st_addr/st_data - data-memory store bus (monitored)
//            done/pass/timeout   - run status (levels)
//            fail_code           - st_data[XLEN-1:1] of a FAIL write
//            cycle_count         - cycles spent in RUN (saturating)
//            instret_count       - instructions retired in RUN (saturating)
//            trace_idx, trace_pc - PC history read port (0 = newest)
// Revision : 1.0 - initial release
// ============================================================================
module proc_test_harness
  import harness_pkg::*;
#(
  parameter int              XLEN           = 32,
  parameter int              RESET_CYCLES   = 4,
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter int              CNT_W          = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = 32'h0000_0FFC,
  parameter int              TRACE_DEPTH    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           core_resetn,
  input  logic                           retire,
  input  logic [XLEN-1:0]                pc,
  input  logic                           st_en,
  input  logic [XLEN-1:0]                st_addr,
  input  logic [XLEN-1:0]                st_data,
  output logic                           done,
  output logic                           pass,
  output logic                           timeout,
  output logic [XLEN-2:0]                fail_code,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               instret_count,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [XLEN-1:0]                trace_pc
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [XLEN-1:0]  PASS_VALUE   = XLEN'(PASS_CODE);

  harness_state_t state;
  logic [7:0]     hold_cnt;

  logic tohost_wr;
  logic completion;
  logic start_ok;

  assign tohost_wr  = st_en && (st_addr == TOHOST_ADDR);
  // Only odd values end the run; even values are progress writes.
  assign completion = tohost_wr && st_data[0];
  assign start_ok   = start && (state != ST_RST_HOLD) && (state != ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      hold_cnt      <= '0;
      core_resetn   <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      timeout       <= 1'b0;
      fail_code     <= '0;
      cycle_count   <= '0;
      instret_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_PASS, ST_FAIL, ST_TIMEOUT: begin
          if (start) begin
            state         <= ST_RST_HOLD;
            hold_cnt      <= hold_preload(RESET_CYCLES);
            core_resetn   <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            fail_code     <= '0;
            cycle_count   <= '0;
            instret_count <= '0;
          end
        end

        ST_RST_HOLD: begin
          if (hold_cnt == 8'd0) begin
            state       <= ST_RUN;
            core_resetn <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt - 8'd1;
          end
        end

        ST_RUN: begin
          // The terminating cycle is itself counted, including its retire.
          if (cycle_count != CNT_MAX) begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
          if (retire && (instret_count != CNT_MAX)) begin
            instret_count <= instret_count + CNT_W'(1);
          end

          // A completion write takes priority over a coincident timeout.
          if (completion) begin
            core_resetn <= 1'b0;
            done        <= 1'b1;
            if (st_data == PASS_VALUE) begin
              state <= ST_PASS;
              pass  <= 1'b1;
            end else begin
              state     <= ST_FAIL;
              fail_code <= st_data[XLEN-1:1];
            end
          end else if (cycle_count == TIMEOUT_LAST) begin
            state       <= ST_TIMEOUT;
            core_resetn <= 1'b0;
            done        <= 1'b1;
            timeout     <= 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          core_resetn <= 1'b0;
        end
      endcase
    end
  end

`ifdef HARNESS_TRACE_EN
  pc_trace_buf #(
    .XLEN  (XLEN),
    .DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk     (clk),
    .reset   (reset),
    .clear   (start_ok),
    .wr_en   (retire && (state == ST_RUN)),
    .wr_data (pc),
    .rd_idx  (trace_idx),
    .rd_data (trace_pc)
  );
`else
  // No history kept: the PC and read index have no consumer.
  logic unused_trace_inputs;
  assign unused_trace_inputs = ^{pc, trace_idx, start_ok};
  assign trace_pc = '0;
`endif

endmodule
`default_nettype wire
